// File: rtl/mem_arb_pkg.sv
// Shared constants and enumerations for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int WORD_W         = 16;
  localparam int CELL_W         = 4;
  localparam int CELLS_PER_WORD = 4;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef enum logic {
    GNT_IF,
    GNT_D
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_cell_sequencer.sv
// Walks the four consecutive memory cells of one word access: owns the cell
// counter, the wrapping cell address, MSB-first write nibbles and read assembly.
module cell_sequencer #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = mem_arb_pkg::WORD_W,
  parameter int CELL_W = mem_arb_pkg::CELL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              active,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [WORD_W-1:0] wdata_in,
  input  logic [CELL_W-1:0] cell_rdata,
  output logic              last_cell,
  output logic [ADDR_W-1:0] cell_addr,
  output logic [CELL_W-1:0] cell_wdata,
  output logic [WORD_W-1:0] word_out
);

  import mem_arb_pkg::*;

  logic [1:0]               cnt;
  logic [ADDR_W-1:0]        base_q;
  logic [WORD_W-1:0]        wr_shift;
  logic [WORD_W-CELL_W-1:0] rd_shift;

  // Latch the access on load, then advance one cell per active cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      base_q   <= '0;
      wr_shift <= '0;
      rd_shift <= '0;
    end else if (load) begin
      cnt      <= '0;
      base_q   <= base_in;
      wr_shift <= wdata_in;
      rd_shift <= '0;
    end else if (active) begin
      cnt      <= cnt + 2'd1;
      wr_shift <= wr_shift << CELL_W;
      rd_shift <= {rd_shift[WORD_W-2*CELL_W-1:0], cell_rdata};
    end
  end

  assign last_cell  = (cnt == 2'(CELLS_PER_WORD - 1));
  assign cell_addr  = base_q + ADDR_W'(cnt);
  assign cell_wdata = wr_shift[WORD_W-1 -: CELL_W];
  assign word_out   = {rd_shift, cell_rdata};

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port nibble-wide memory between an instruction-fetch port
// and a data port; each word takes four cell cycles plus one completion cycle.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = mem_arb_pkg::WORD_W,
  parameter int CELL_W = mem_arb_pkg::CELL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic              if_ready,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [CELL_W-1:0] mem_wdata,
  input  logic [CELL_W-1:0] mem_rdata
);

  import mem_arb_pkg::*;

  state_t            state_q;
  state_t            state_d;
  grant_t            gnt_q;
  grant_t            gnt_d;
  logic              grant_valid;
  logic              we_q;
  logic              last_was_data;
  logic              if_elig;
  logic              d_elig;
  logic              done;
  logic              last_cell;
  logic [ADDR_W-1:0] cell_addr;
  logic [CELL_W-1:0] cell_wdata;
  logic [WORD_W-1:0] word_out;
  logic [ADDR_W-1:0] seq_base;
  logic [WORD_W-1:0] seq_wdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[WORD_W-1:ADDR_W], d_addr[WORD_W-1:ADDR_W]};

  // A port that is completing this cycle must not be regranted in the same cycle.
  assign if_elig = if_req & ~if_ready;
  assign d_elig  = d_req & ~d_ready;

  // Next-state and grant decision; data wins a tie unless it won the last one.
  always_comb begin
    state_d     = state_q;
    grant_valid = 1'b0;
    gnt_d       = GNT_D;
    case (state_q)
      IDLE: begin
        if (if_elig && d_elig) begin
          grant_valid = 1'b1;
          gnt_d       = last_was_data ? GNT_IF : GNT_D;
        end else if (d_elig) begin
          grant_valid = 1'b1;
          gnt_d       = GNT_D;
        end else if (if_elig) begin
          grant_valid = 1'b1;
          gnt_d       = GNT_IF;
        end
        if (grant_valid) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (last_cell) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Remember who owns the access in flight and whether it writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q         <= GNT_IF;
      we_q          <= 1'b0;
      last_was_data <= 1'b0;
    end else if (grant_valid) begin
      gnt_q         <= gnt_d;
      we_q          <= (gnt_d == GNT_D) && d_we;
      last_was_data <= (gnt_d == GNT_D);
    end
  end

  assign done = (state_q == ACCESS) && last_cell;

  // Completion pulse and read-data capture on the last cell of an access.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_ready <= done && (gnt_q == GNT_IF);
      d_ready  <= done && (gnt_q == GNT_D);
      if (done && !we_q) begin
        if (gnt_q == GNT_IF) begin
          if_rdata <= word_out;
        end else begin
          d_rdata <= word_out;
        end
      end
    end
  end

  assign seq_base  = (gnt_d == GNT_D) ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
  assign seq_wdata = ((gnt_d == GNT_D) && d_we) ? d_wdata : '0;

  cell_sequencer #(
    .ADDR_W(ADDR_W),
    .WORD_W(WORD_W),
    .CELL_W(CELL_W)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .load      (grant_valid),
    .active    (state_q == ACCESS),
    .base_in   (seq_base),
    .wdata_in  (seq_wdata),
    .cell_rdata(mem_rdata),
    .last_cell (last_cell),
    .cell_addr (cell_addr),
    .cell_wdata(cell_wdata),
    .word_out  (word_out)
  );

  assign mem_addr  = (state_q == ACCESS) ? cell_addr : '0;
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign mem_wdata = mem_we ? cell_wdata : '0;

  assign if_stall = if_req & ~if_ready;
  assign d_stall  = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural nibble memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ready;
  logic [15:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ready;
  logic [15:0] d_rdata;
  logic        d_stall;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata;

  logic [3:0]  mem [0:255];
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [3:0]  pre_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural memory: bench preload port or DUT write, combinational read.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign mem_rdata = mem[mem_addr];

  mem_port_arbiter #(.ADDR_W(8), .WORD_W(16), .CELL_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_rdata (if_rdata),
    .if_stall (if_stall),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .d_stall  (d_stall),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [15:0] iaddr, input logic dreq,
                               input logic dwe, input logic [15:0] daddr, input logic [15:0] dwdata);
    if_req  = ireq;
    if_addr = iaddr;
    d_req   = dreq;
    d_we    = dwe;
    d_addr  = daddr;
    d_wdata = dwdata;
    #1;
  endtask

  task automatic preload(input logic [7:0] addr, input logic [3:0] data);
    pre_en   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    tick();
    pre_en   = 1'b0;
  endtask

  initial begin
    logic [15:0] wword;
    logic [7:0]  eaddr;
    logic        is_d;
    logic        exp_dr;
    logic        exp_ir;

    rst    = 1'b1;
    pre_en = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

    preload(8'd8, 4'h3);
    preload(8'd9, 4'h1);
    preload(8'd10, 4'h0);
    preload(8'd11, 4'hA);
    preload(8'hFE, 4'h1);
    preload(8'hFF, 4'h2);
    preload(8'h00, 4'h3);
    preload(8'h01, 4'h4);
    tick();

    // Reset state
    checkOutput("rst_if_ready", 16'(if_ready), 16'h0);
    checkOutput("rst_d_ready", 16'(d_ready), 16'h0);
    checkOutput("rst_if_rdata", if_rdata, 16'h0);
    checkOutput("rst_d_rdata", d_rdata, 16'h0);
    checkOutput("rst_mem_addr", 16'(mem_addr), 16'h0);
    checkOutput("rst_mem_we", 16'(mem_we), 16'h0);
    checkOutput("rst_mem_wdata", 16'(mem_wdata), 16'h0);
    rst = 1'b0;

    // Fetch read of cells 8..11 = 3,1,0,A
    applyStimulus(1'b1, 16'd8, 1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("fetch_stall_grant", 16'(if_stall), 16'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("fetch_addr_%0d", k), 16'(mem_addr), 16'(8 + k));
      checkOutput($sformatf("fetch_we_%0d", k), 16'(mem_we), 16'h0);
    end
    tick();
    checkOutput("fetch_ready", 16'(if_ready), 16'h1);
    checkOutput("fetch_rdata", if_rdata, 16'h310A);
    checkOutput("fetch_stall_ready", 16'(if_stall), 16'h0);
    checkOutput("fetch_d_ready", 16'(d_ready), 16'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    checkOutput("fetch_ready_once", 16'(if_ready), 16'h0);

    // Data write of 0x9CF0 at 24
    wword = 16'h9CF0;
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'd24, 16'h9CF0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("wr_addr_%0d", k), 16'(mem_addr), 16'(24 + k));
      checkOutput($sformatf("wr_we_%0d", k), 16'(mem_we), 16'h1);
      checkOutput($sformatf("wr_wdata_%0d", k), 16'(mem_wdata), 16'(wword[15-4*k -: 4]));
    end
    tick();
    checkOutput("wr_ready", 16'(d_ready), 16'h1);
    checkOutput("wr_rdata_kept", d_rdata, 16'h0);
    checkOutput("wr_mem24", 16'(mem[24]), 16'h9);
    checkOutput("wr_mem25", 16'(mem[25]), 16'hC);
    checkOutput("wr_mem26", 16'(mem[26]), 16'hF);
    checkOutput("wr_mem27", 16'(mem[27]), 16'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();

    // Data read back of 24
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'd24, 16'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("rd_we_%0d", k), 16'(mem_we), 16'h0);
    end
    tick();
    checkOutput("rd_ready", 16'(d_ready), 16'h1);
    checkOutput("rd_rdata", d_rdata, 16'h9CF0);
    checkOutput("rd_if_rdata_kept", if_rdata, 16'h310A);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();

    // Fetch wrapping across the top of memory
    applyStimulus(1'b1, 16'h00FE, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      eaddr = 8'hFE + 8'(k);
      checkOutput($sformatf("wrap_addr_%0d", k), 16'(mem_addr), 16'(eaddr));
    end
    tick();
    checkOutput("wrap_ready", 16'(if_ready), 16'h1);
    checkOutput("wrap_rdata", if_rdata, 16'h1234);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();

    // Fetch request held through its ready cycle
    applyStimulus(1'b1, 16'd8, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 4; k++) tick();
    tick();
    checkOutput("hold_ready", 16'(if_ready), 16'h1);
    tick();
    checkOutput("hold_no_regrant_addr", 16'(mem_addr), 16'h0);
    checkOutput("hold_ready_low", 16'(if_ready), 16'h0);
    checkOutput("hold_stall", 16'(if_stall), 16'h1);
    tick();
    checkOutput("hold_regrant_addr", 16'(mem_addr), 16'd8);
    for (int k = 0; k < 3; k++) tick();
    tick();
    checkOutput("hold_ready2", 16'(if_ready), 16'h1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();

    // Both ports requesting continuously from reset: D, F, D, F
    rst = 1'b1;
    applyStimulus(1'b1, 16'd8, 1'b1, 1'b0, 16'd24, 16'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("arb_d_stall_start", 16'(d_stall), 16'h1);
    checkOutput("arb_if_stall_start", 16'(if_stall), 16'h1);
    for (int c = 1; c <= 20; c++) begin
      tick();
      is_d   = (((c - 1) / 5) % 2) == 0;
      exp_dr = ((c % 5) == 0) && (((c / 5 - 1) % 2) == 0);
      exp_ir = ((c % 5) == 0) && (((c / 5 - 1) % 2) == 1);
      if (((c - 1) % 5) == 0)
        checkOutput($sformatf("arb_addr_c%0d", c), 16'(mem_addr), is_d ? 16'd24 : 16'd8);
      checkOutput($sformatf("arb_d_ready_c%0d", c), 16'(d_ready), 16'(exp_dr));
      checkOutput($sformatf("arb_if_ready_c%0d", c), 16'(if_ready), 16'(exp_ir));
      checkOutput($sformatf("arb_d_stall_c%0d", c), 16'(d_stall), 16'(!exp_dr));
      checkOutput($sformatf("arb_if_stall_c%0d", c), 16'(if_stall), 16'(!exp_ir));
    end
    checkOutput("arb_d_rdata", d_rdata, 16'h9CF0);
    checkOutput("arb_if_rdata", if_rdata, 16'h310A);

    // Reset in the second cell of a write of 0xABCD at 40
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    preload(8'd40, 4'h5);
    preload(8'd41, 4'h5);
    preload(8'd42, 4'h5);
    preload(8'd43, 4'h5);
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'd40, 16'hABCD);
    tick();
    checkOutput("abort_addr0", 16'(mem_addr), 16'd40);
    tick();
    checkOutput("abort_addr1", 16'(mem_addr), 16'd41);
    checkOutput("abort_we1", 16'(mem_we), 16'h1);
    rst = 1'b1;
    #1;
    tick();
    checkOutput("abort_mem_we", 16'(mem_we), 16'h0);
    checkOutput("abort_mem_addr", 16'(mem_addr), 16'h0);
    checkOutput("abort_mem_wdata", 16'(mem_wdata), 16'h0);
    checkOutput("abort_d_ready", 16'(d_ready), 16'h0);
    checkOutput("abort_if_ready", 16'(if_ready), 16'h0);
    checkOutput("abort_d_rdata", d_rdata, 16'h0);
    checkOutput("abort_if_rdata", if_rdata, 16'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    tick();
    checkOutput("abort_d_ready_later", 16'(d_ready), 16'h0);
    checkOutput("abort_mem40", 16'(mem[40]), 16'hA);
    checkOutput("abort_mem41", 16'(mem[41]), 16'hB);
    checkOutput("abort_mem42", 16'(mem[42]), 16'h5);
    checkOutput("abort_mem43", 16'(mem[43]), 16'h5);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput($sformatf("abort_idle_ready_%0d", k), 16'(d_ready), 16'h0);
      checkOutput($sformatf("abort_idle_we_%0d", k), 16'(mem_we), 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
